pc_stack_unit: RTL and testbench
================================

// Module: pc_stack_unit
// PURPOSE
//  Parametrised program-counter unit for the 4-bit processor core: increment, jump and
//  subroutine CALL/RET backed by an internal return-address LIFO. Sits between the
//  decoder and the program ROM; pc drives the ROM address. Load is fully synchronous.
// PARAMETERS
//  ADDR_W      12  width of pc, target and stack entries
//  STACK_DEPTH 8   return-address entries (>=2); DEPTH_W = $clog2(STACK_DEPTH+1)
//  RESET_PC    0   pc value after reset
// PORTS
//  clock       in   1        single clock; all state updates on its rising edge
//  reset       in   1        synchronous, active-low: reset==0 at a rising edge resets all state
//  inc         in   1        pc <= pc+1
//  load        in   1        jump: pc <= target
//  call        in   1        push pc+1, pc <= target
//  ret         in   1        pc <= popped address
//  clr_err     in   1        clear sticky error flags
//  target      in   ADDR_W   jump/call destination ({oprnd, program_byte} at top level)
//  pc          out  ADDR_W   current program counter
//  depth       out  DEPTH_W  number of valid stack entries
//  stack_full  out  1        depth == STACK_DEPTH
//  stack_empty out  1        depth == 0
//  ovf_err     out  1        sticky: CALL attempted while full
//  unf_err     out  1        sticky: RET attempted while empty
// BEHAVIOUR
//  - Reset: pc=RESET_PC, depth=0, stack_empty=1, stack_full=0, ovf_err=0, unf_err=0;
//    stack contents don't-care. Reset overrides every other input.
//  - One operation per cycle, fixed priority: ret > call > load > inc > hold.
//    Lower-priority requests asserted in the same cycle are ignored, not queued.
//  - Latency: every effect visible on pc/depth/flags the cycle after the sampling edge.
//  - inc: pc <= pc+1 modulo 2^ADDR_W (max value wraps to 0, no flag).
//  - load: pc <= target; stack untouched.
//  - call, not full: stack[depth] <= pc+1 (wrapped), depth+1, pc <= target.
//  - call, full: no push, pc holds (no jump), ovf_err <= 1.
//  - ret, not empty: pc <= stack[depth-1], depth-1.
//  - ret, empty: pc holds, depth stays 0, unf_err <= 1.
//  - stack_full/stack_empty decoded combinationally from registered depth.
//  - clr_err clears both error flags; if an error event occurs the same cycle, set wins.
//  - Errors never block further operation; the decoder decides whether to halt.
// STRUCTURE
//  - Shared package: op priority encoding (OP_RET, OP_CALL, OP_LOAD, OP_INC, OP_HOLD)
//    and default ADDR_W shared with the PROM and decoder.
//  - One sub-module: pc_ret_stack (LIFO, STACK_DEPTH x ADDR_W, push/pop/depth, sync
//    active-low reset of depth only); top holds pc register, priority mux and error flags.
// TESTING
//  1 reset=0 for 2 cycles with inc=1 -> pc=0, depth=0, stack_empty=1, both errors 0.
//  2 inc from pc=12'hFFE for 3 cycles -> pc 12'hFFF, 12'h000, 12'h001; no flags.
//  3 pc=12'h010, call target=12'h200 -> pc=12'h200, depth=1; ret -> pc=12'h011, depth=0.
//  4 STACK_DEPTH calls then one more call (target=12'h300) -> stack_full=1, pc unchanged,
//    ovf_err=1; STACK_DEPTH rets return addresses in reverse order; extra ret -> unf_err=1.
//  5 same cycle ret=1, call=1, load=1, inc=1 with depth=1 -> only pop happens; then
//    load=1 + inc=1, target=12'h0A5 -> pc=12'h0A5.
//  6 reset=0 mid-sequence at depth=3 -> pc=RESET_PC, depth=0; clr_err with simultaneous
//    ret-on-empty -> unf_err remains 1.

Source files
------------

// File: rtl/pc_stack_unit_pkg.sv
// Shared definitions for the program-counter unit, PROM and decoder.
// Holds the operation priority encoding and the default address width.
package pc_stack_unit_pkg;

  localparam int DEFAULT_ADDR_W = 12;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_LOAD = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } op_e;

  // Fixed priority: ret > call > load > inc > hold.
  function automatic op_e decode_op(input logic ret, input logic call,
                                    input logic load, input logic inc);
    if (ret)       return OP_RET;
    else if (call) return OP_CALL;
    else if (load) return OP_LOAD;
    else if (inc)  return OP_INC;
    else           return OP_HOLD;
  endfunction

endpackage

// File: rtl/pc_stack_unit_ret_stack.sv
// Return-address LIFO. Only the depth counter is reset; entries are don't-care.
// Caller guarantees push only when not full and pop only when not empty.
module pc_ret_stack
  import pc_stack_unit_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int STACK_DEPTH = 8,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [ADDR_W-1:0]  push_data,
  output logic [ADDR_W-1:0]  top_data,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  localparam int                 IDX_W    = $clog2(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] FULL_CNT = DEPTH_W'(STACK_DEPTH);

  logic [ADDR_W-1:0]  mem [STACK_DEPTH];
  logic [DEPTH_W-1:0] top_ptr;

  assign top_ptr  = depth - DEPTH_W'(1);
  assign top_data = mem[top_ptr[IDX_W-1:0]];
  assign full     = (depth == FULL_CNT);
  assign empty    = (depth == '0);

  always_ff @(posedge clock) begin
    if (!reset)    depth <= '0;
    else if (push) depth <= depth + DEPTH_W'(1);
    else if (pop)  depth <= depth - DEPTH_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset && push) mem[depth[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with increment, jump and CALL/RET through an internal LIFO.
// Holds the pc register, the operation priority mux and the sticky error flags.
module pc_stack_unit
  import pc_stack_unit_pkg::*;
#(
  parameter int                ADDR_W      = DEFAULT_ADDR_W,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inc,
  input  logic               load,
  input  logic               call,
  input  logic               ret,
  input  logic               clr_err,
  input  logic [ADDR_W-1:0]  target,
  output logic [ADDR_W-1:0]  pc,
  output logic [DEPTH_W-1:0] depth,
  output logic               stack_full,
  output logic               stack_empty,
  output logic               ovf_err,
  output logic               unf_err
);

  op_e               op;
  logic [ADDR_W-1:0] pc_next_seq;
  logic [ADDR_W-1:0] top_data;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              unf_set;

  assign op          = decode_op(ret, call, load, inc);
  assign pc_next_seq = pc + ADDR_W'(1);
  assign push        = (op == OP_CALL) && !stack_full;
  assign pop         = (op == OP_RET) && !stack_empty;
  assign ovf_set     = (op == OP_CALL) && stack_full;
  assign unf_set     = (op == OP_RET) && stack_empty;

  pc_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .DEPTH_W     (DEPTH_W)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_next_seq),
    .top_data  (top_data),
    .depth     (depth),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      case (op)
        OP_RET:  if (pop)  pc <= top_data;
        OP_CALL: if (push) pc <= target;
        OP_LOAD: pc <= target;
        OP_INC:  pc <= pc_next_seq;
        default: pc <= pc;
      endcase
      // A new error event wins over a simultaneous clear.
      ovf_err <= ovf_set | (ovf_err & ~clr_err);
      unf_err <= unf_set | (unf_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed and randomized checks of pc_stack_unit against a queue-based model.
module tb_pc_stack_unit;

  localparam int ADDR_W = 12;
  localparam int SDEPTH = 8;
  localparam int DW     = $clog2(SDEPTH + 1);

  logic              clock = 1'b0;
  logic              reset, inc, load, call, ret, clr_err;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc;
  logic [DW-1:0]     depth;
  logic              stack_full, stack_empty, ovf_err, unf_err;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W-1:0] m_stack[$];
  logic              m_ovf, m_unf;

  pc_stack_unit #(.ADDR_W(ADDR_W), .STACK_DEPTH(SDEPTH), .RESET_PC('0)) dut (
    .clock(clock), .reset(reset), .inc(inc), .load(load), .call(call), .ret(ret),
    .clr_err(clr_err), .target(target), .pc(pc), .depth(depth),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (!reset) begin
      m_pc = '0;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (clr_err) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (ret) begin
        if (m_stack.size() == 0) m_unf = 1'b1;
        else m_pc = m_stack.pop_back();
      end else if (call) begin
        if (m_stack.size() == SDEPTH) m_ovf = 1'b1;
        else begin
          m_stack.push_back(ADDR_W'((int'(m_pc) + 1) % (1 << ADDR_W)));
          m_pc = target;
        end
      end else if (load) begin
        m_pc = target;
      end else if (inc) begin
        m_pc = ADDR_W'((int'(m_pc) + 1) % (1 << ADDR_W));
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    32'(pc),          32'(m_pc));
    check({tag, ".depth"}, 32'(depth),       32'(m_stack.size()));
    check({tag, ".full"},  32'(stack_full),  32'(m_stack.size() == SDEPTH));
    check({tag, ".empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
    check({tag, ".ovf"},   32'(ovf_err),     32'(m_ovf));
    check({tag, ".unf"},   32'(unf_err),     32'(m_unf));
  endtask

  task automatic step(input string tag, input logic rst_n, input logic i, input logic l,
                      input logic c, input logic r, input logic clr,
                      input logic [ADDR_W-1:0] tgt);
    reset = rst_n; inc = i; load = l; call = c; ret = r; clr_err = clr; target = tgt;
    @(posedge clock);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0; inc = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0;
    clr_err = 1'b0; target = '0;
    m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0;
    #2;

    // reset wins over inc
    step("rst0", 0, 1, 0, 0, 0, 0, '0);
    step("rst1", 0, 1, 0, 0, 0, 0, '0);
    check("rst.pc_const", 32'(pc), 32'h0);
    check("rst.empty_const", 32'(stack_empty), 32'h1);

    // increment wrap
    step("ld_ffe", 1, 0, 1, 0, 0, 0, 12'hFFE);
    step("inc_a", 1, 1, 0, 0, 0, 0, '0);
    check("inc.fff", 32'(pc), 32'hFFF);
    step("inc_b", 1, 1, 0, 0, 0, 0, '0);
    check("inc.wrap", 32'(pc), 32'h000);
    step("inc_c", 1, 1, 0, 0, 0, 0, '0);
    check("inc.001", 32'(pc), 32'h001);

    // simple call/ret
    step("ld_010", 1, 0, 1, 0, 0, 0, 12'h010);
    step("call_200", 1, 0, 0, 1, 0, 0, 12'h200);
    check("call.pc", 32'(pc), 32'h200);
    step("ret_011", 1, 0, 0, 0, 1, 0, '0);
    check("ret.pc", 32'(pc), 32'h011);

    // fill, overflow, drain, underflow
    step("ld_000", 1, 0, 1, 0, 0, 0, 12'h000);
    for (int k = 0; k < SDEPTH; k++) step("fill", 1, 0, 0, 1, 0, 0, ADDR_W'(12'h100 + 16 * k));
    check("fill.full", 32'(stack_full), 32'h1);
    step("ovf_call", 1, 0, 0, 1, 0, 0, 12'h300);
    check("ovf.flag", 32'(ovf_err), 32'h1);
    check("ovf.pc_held", 32'(pc), 32'h170);
    for (int k = 0; k < SDEPTH; k++) step("drain", 1, 0, 0, 0, 1, 0, '0);
    check("drain.last", 32'(pc), 32'h001);
    step("unf_ret", 1, 0, 0, 0, 1, 0, '0);
    check("unf.flag", 32'(unf_err), 32'h1);
    step("clr", 1, 0, 0, 0, 0, 1, '0);

    // priority: only the pop happens
    step("ld_040", 1, 0, 1, 0, 0, 0, 12'h040);
    step("call_050", 1, 0, 0, 1, 0, 0, 12'h050);
    step("prio_all", 1, 1, 1, 1, 1, 0, 12'h3AA);
    check("prio.pc", 32'(pc), 32'h041);
    step("ld_inc", 1, 1, 1, 0, 0, 0, 12'h0A5);
    check("ldinc.pc", 32'(pc), 32'h0A5);

    // reset mid-sequence, then clear colliding with a new underflow
    for (int k = 0; k < 3; k++) step("pre_rst", 1, 0, 0, 1, 0, 0, ADDR_W'(12'h400 + k));
    step("mid_rst", 0, 0, 0, 1, 0, 0, 12'h7FF);
    check("midrst.depth", 32'(depth), 32'h0);
    step("unf_set", 1, 0, 0, 0, 1, 0, '0);
    step("clr_vs_unf", 1, 0, 0, 0, 1, 1, '0);
    check("clrset.unf", 32'(unf_err), 32'h1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic r_rst, r_i, r_l, r_c, r_r, r_clr;
      r_rst = ($urandom_range(0, 79) != 0);
      r_i   = $urandom_range(0, 1) == 1;
      r_l   = $urandom_range(0, 5) == 0;
      r_c   = $urandom_range(0, 3) == 0;
      r_r   = $urandom_range(0, 3) == 0;
      r_clr = $urandom_range(0, 9) == 0;
      step("rand", r_rst, r_i, r_l, r_c, r_r, r_clr, ADDR_W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
